// File: rtl/tile_region_mapper.sv
// Maps raster pixels to per-panel tile row/column indices using running counters.
// Optional macro TILE_BORDER_EN adds the on_border output.
module tile_region_mapper #(
  parameter int unsigned NUM_PANELS = 2,
  parameter int unsigned PANEL_ROWS = 20,
  parameter int unsigned PANEL_COLS = 10,
  parameter int unsigned TILE_W     = 20,
  parameter int unsigned TILE_H     = 24,
  parameter logic [NUM_PANELS*10-1:0] PANEL_HSTART = {10'd230, 10'd130},
  parameter logic [NUM_PANELS*10-1:0] PANEL_VSTART = {10'd176, 10'd80}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_valid,
  input  logic [9:0]                 h_pos,
  input  logic [9:0]                 v_pos,
  output logic [NUM_PANELS-1:0]      in_panel,
  output logic [NUM_PANELS*5-1:0]    tile_row,
  output logic [NUM_PANELS*5-1:0]    tile_col,
  output logic                       frame_start,
  output logic                       seq_err
`ifdef TILE_BORDER_EN
  ,
  output logic [NUM_PANELS-1:0]      on_border
`endif
);

  localparam int unsigned POS_W  = 10;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned SUB_W  = 6;
  localparam int unsigned CMP_W  = 16;
  localparam int unsigned H_SPAN = PANEL_COLS * TILE_W;
  localparam int unsigned V_SPAN = PANEL_ROWS * TILE_H;

  logic [SUB_W-1:0] r_sx  [NUM_PANELS];
  logic [SUB_W-1:0] r_sy  [NUM_PANELS];
  logic [IDX_W-1:0] r_col [NUM_PANELS];
  logic [IDX_W-1:0] r_row [NUM_PANELS];
  logic [POS_W-1:0] r_last_h;
  logic [POS_W-1:0] r_last_v;
  logic             r_have_line;

  logic [SUB_W-1:0] w_sx  [NUM_PANELS];
  logic [SUB_W-1:0] w_sy  [NUM_PANELS];
  logic [IDX_W-1:0] w_col [NUM_PANELS];
  logic [IDX_W-1:0] w_row [NUM_PANELS];
  logic [POS_W-1:0] w_hs  [NUM_PANELS];
  logic [POS_W-1:0] w_vs  [NUM_PANELS];
  logic [NUM_PANELS-1:0] w_in;
  logic             w_new_line;
  logic             w_seq_bad;

  for (genvar gp = 0; gp < NUM_PANELS; gp++) begin : g_origin
    assign w_hs[gp] = PANEL_HSTART[gp*POS_W +: POS_W];
    assign w_vs[gp] = PANEL_VSTART[gp*POS_W +: POS_W];
  end

  // Line tracking and raster-order check; reset clears history so the next pixel opens a line.
  always_comb begin
    w_new_line = 1'b0;
    w_seq_bad  = 1'b0;
    if (pix_valid) begin
      w_new_line = !r_have_line || (v_pos != r_last_v);
      w_seq_bad  = !w_new_line && (h_pos != (r_last_h + POS_W'(1)));
    end
  end

  // Per-panel next counter values; they advance only on valid pixels.
  always_comb begin
    for (int p = 0; p < NUM_PANELS; p++) begin
      w_sx[p]  = r_sx[p];
      w_sy[p]  = r_sy[p];
      w_col[p] = r_col[p];
      w_row[p] = r_row[p];
      w_in[p]  = 1'b0;
      if (pix_valid) begin
        if (h_pos == w_hs[p]) begin
          w_sx[p]  = '0;
          w_col[p] = '0;
        end else if (r_sx[p] == SUB_W'(TILE_W - 1)) begin
          w_sx[p] = '0;
          if (r_col[p] != IDX_W'(PANEL_COLS - 1)) begin
            w_col[p] = r_col[p] + IDX_W'(1);
          end
        end else begin
          w_sx[p] = r_sx[p] + SUB_W'(1);
        end

        if (w_new_line) begin
          if (v_pos == w_vs[p]) begin
            w_sy[p]  = '0;
            w_row[p] = '0;
          end else if (r_sy[p] == SUB_W'(TILE_H - 1)) begin
            w_sy[p] = '0;
            if (r_row[p] != IDX_W'(PANEL_ROWS - 1)) begin
              w_row[p] = r_row[p] + IDX_W'(1);
            end
          end else begin
            w_sy[p] = r_sy[p] + SUB_W'(1);
          end
        end

        w_in[p] = (CMP_W'(h_pos) >= CMP_W'(w_hs[p])) &&
                  (CMP_W'(h_pos) <  CMP_W'(w_hs[p]) + CMP_W'(H_SPAN)) &&
                  (CMP_W'(v_pos) >= CMP_W'(w_vs[p])) &&
                  (CMP_W'(v_pos) <  CMP_W'(w_vs[p]) + CMP_W'(V_SPAN));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PANELS; p++) begin
        r_sx[p]  <= '0;
        r_sy[p]  <= '0;
        r_col[p] <= '0;
        r_row[p] <= '0;
      end
      r_last_h    <= '0;
      r_last_v    <= '0;
      r_have_line <= 1'b0;
      in_panel    <= '0;
      tile_row    <= '0;
      tile_col    <= '0;
      frame_start <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PANELS; p++) begin
        r_sx[p]  <= w_sx[p];
        r_sy[p]  <= w_sy[p];
        r_col[p] <= w_col[p];
        r_row[p] <= w_row[p];
        tile_row[p*IDX_W +: IDX_W] <= w_in[p] ? w_row[p] : '0;
        tile_col[p*IDX_W +: IDX_W] <= w_in[p] ? w_col[p] : '0;
      end
      if (pix_valid) begin
        r_last_h    <= h_pos;
        r_last_v    <= v_pos;
        r_have_line <= 1'b1;
      end
      in_panel    <= w_in;
      frame_start <= pix_valid && (h_pos == '0) && (v_pos == '0);
      seq_err     <= seq_err | w_seq_bad;
    end
  end

`ifdef TILE_BORDER_EN
  // Border marks the first pixel column and first pixel row of every tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      on_border <= '0;
    end else begin
      for (int p = 0; p < NUM_PANELS; p++) begin
        on_border[p] <= w_in[p] && ((w_sx[p] == '0) || (w_sy[p] == '0));
      end
    end
  end
`endif

endmodule

// File: tb/tb_tile_region_mapper.sv
// Directed bench for tile_region_mapper with default parameters.
module tb_tile_region_mapper;

  logic       clk;
  logic       rst;
  logic       pix_valid;
  logic [9:0] h_pos;
  logic [9:0] v_pos;
  logic [1:0] in_panel;
  logic [9:0] tile_row;
  logic [9:0] tile_col;
  logic       frame_start;
  logic       seq_err;
`ifdef TILE_BORDER_EN
  logic [1:0] on_border;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  tile_region_mapper dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .h_pos       (h_pos),
    .v_pos       (v_pos),
    .in_panel    (in_panel),
    .tile_row    (tile_row),
    .tile_col    (tile_col),
    .frame_start (frame_start),
    .seq_err     (seq_err)
`ifdef TILE_BORDER_EN
    ,
    .on_border   (on_border)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Apply one pixel, then sample one time unit after the capturing edge.
  task automatic step(input logic valid, input int h, input int v);
    pix_valid = valid;
    h_pos     = 10'(h);
    v_pos     = 10'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) step(1'b1, h, v);
  endtask

  initial begin
    rst = 1'b1;
    pix_valid = 1'b0;
    h_pos = '0;
    v_pos = '0;
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    check("rst_in_panel", 32'(in_panel), 0);
    check("rst_tile_row", 32'(tile_row), 0);
    check("rst_tile_col", 32'(tile_col), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_seq_err", 32'(seq_err), 0);
    rst = 1'b0;

    step(1'b0, 0, 0);
    check("fs_invalid", 32'(frame_start), 0);
    step(1'b1, 0, 0);
    check("fs_pulse", 32'(frame_start), 1);
    step(1'b1, 1, 0);
    check("fs_drop", 32'(frame_start), 0);
    check("outside_in_panel", 32'(in_panel), 0);

    run_line(80, 120, 129);
    check("h129_in_panel", 32'(in_panel), 0);
    step(1'b1, 130, 80);
    check("p130_80_in_panel", 32'(in_panel), 1);
    check("p130_80_row", 32'(tile_row[4:0]), 0);
    check("p130_80_col", 32'(tile_col[4:0]), 0);
`ifdef TILE_BORDER_EN
    check("p130_80_border", 32'(on_border[0]), 1);
`endif
    run_line(80, 131, 149);
    check("p149_80_col", 32'(tile_col[4:0]), 0);
    step(1'b1, 150, 80);
    check("p150_80_col", 32'(tile_col[4:0]), 1);

    run_line(81, 129, 130);
    step(1'b1, 131, 81);
    check("p131_81_row", 32'(tile_row[4:0]), 0);
    check("p131_81_col", 32'(tile_col[4:0]), 0);
`ifdef TILE_BORDER_EN
    check("p131_81_border", 32'(on_border[0]), 0);
`endif
    for (int v = 82; v <= 103; v++) run_line(v, 129, 131);

    run_line(104, 129, 140);
    step(1'b0, 141, 104);
    check("idle_in_panel", 32'(in_panel), 0);
    check("idle_tile_col", 32'(tile_col), 0);
    run_line(104, 141, 149);
    step(1'b1, 150, 104);
    check("p150_104_row", 32'(tile_row[4:0]), 1);
    check("p150_104_col", 32'(tile_col[4:0]), 1);
`ifdef TILE_BORDER_EN
    check("p150_104_border", 32'(on_border[0]), 1);
`endif

    for (int v = 105; v <= 558; v++) run_line(v, 129, 131);
    run_line(559, 129, 328);
    step(1'b1, 329, 559);
    check("p329_559_in_panel", 32'(in_panel), 3);
    check("p329_559_row0", 32'(tile_row[4:0]), 19);
    check("p329_559_col0", 32'(tile_col[4:0]), 9);
    check("p329_559_row1", 32'(tile_row[9:5]), 15);
    check("p329_559_col1", 32'(tile_col[9:5]), 4);
    step(1'b1, 330, 559);
    check("p330_559_in_panel0", 32'(in_panel[0]), 0);
    check("p330_559_idx0", 32'({tile_row[4:0], tile_col[4:0]}), 0);
    check("p330_559_col1", 32'(tile_col[9:5]), 5);
    check("seq_err_clean", 32'(seq_err), 0);

    run_line(560, 200, 201);
    check("seq_ok_201", 32'(seq_err), 0);
    step(1'b1, 203, 560);
    check("seq_err_set", 32'(seq_err), 1);
    step(1'b1, 204, 560);
    step(1'b0, 205, 560);
    check("seq_err_held", 32'(seq_err), 1);

    step(1'b1, 249, 300);
    rst = 1'b1;
    step(1'b1, 250, 300);
    check("midrst_in_panel", 32'(in_panel), 0);
    check("midrst_rows", 32'(tile_row), 0);
    check("midrst_cols", 32'(tile_col), 0);
    check("midrst_seq_err", 32'(seq_err), 0);
    rst = 1'b0;
    step(1'b1, 251, 300);
    check("postrst_in_panel", 32'(in_panel), 3);
    check("postrst_idx", 32'({tile_row, tile_col}), 0);
    check("postrst_seq_err", 32'(seq_err), 0);

    run_line(80, 129, 129);
    step(1'b1, 130, 80);
    check("restart_in_panel", 32'(in_panel), 1);
    check("restart_idx", 32'({tile_row[4:0], tile_col[4:0]}), 0);
    run_line(80, 131, 150);
    step(1'b1, 151, 80);
    check("restart_col", 32'(tile_col[4:0]), 1);
    for (int v = 81; v <= 103; v++) run_line(v, 129, 131);
    step(1'b1, 130, 104);
    check("restart_row", 32'(tile_row[4:0]), 1);
    check("restart_seq_err", 32'(seq_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tile_region_mapper.md
TILE_REGION_MAPPER -- requirements
Module: tile_region_mapper

Interface
REQ-001 SHALL have parameter NUM_PANELS, default 2: number of independent tile regions mapped in parallel (1-4).
REQ-002 SHALL have parameter PANEL_ROWS, default 20: tile rows per panel.
REQ-003 SHALL have parameter PANEL_COLS, default 10: tile columns per panel.
REQ-004 SHALL have parameters TILE_W and TILE_H, defaults 20 and 24: tile size in pixels, each 1-63.
REQ-005 SHALL have parameters PANEL_HSTART and PANEL_VSTART, each NUM_PANELS*10 bits: per-panel pixel origin, panel p in bits [10p+9:10p].
REQ-006 SHALL have port clk, input, 1: single clock.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port pix_valid, input, 1: h_pos/v_pos are an active-area pixel this cycle.
REQ-009 SHALL have ports h_pos and v_pos, input, 10 each: raster pixel coordinates.
REQ-010 SHALL have port in_panel, output, NUM_PANELS: pixel lies inside panel p.
REQ-011 SHALL have port tile_row, output, NUM_PANELS*5: per-panel tile row index.
REQ-012 SHALL have port tile_col, output, NUM_PANELS*5: per-panel tile column index.
REQ-013 SHALL have port frame_start, output, 1: one-cycle pulse on pixel (0,0).
REQ-014 SHALL have port seq_err, output, 1: sticky raster-order violation flag.

Function
REQ-015 All outputs SHALL be registered; latency is exactly 1 cycle from the sampled pix_valid/h_pos/v_pos to the corresponding outputs.
REQ-016 SHALL compute tile indices with per-panel sub-tile and tile counters only; no divider or multiplier on the pixel path.
REQ-017 Horizontal: when h_pos==HSTART[p], sub-x clears to 0 and column clears to 0; each later valid pixel increments sub-x; at sub-x==TILE_W-1 it wraps to 0 and column increments.
REQ-018 Vertical: on the first valid pixel of a new line (v_pos differs from last valid v_pos), when v_pos==VSTART[p], sub-y and row clear to 0; otherwise sub-y increments and wraps at TILE_H-1 with row increment.
REQ-019 in_panel[p] SHALL be 1 iff pix_valid and HSTART[p] <= h_pos < HSTART[p]+PANEL_COLS*TILE_W and VSTART[p] <= v_pos < VSTART[p]+PANEL_ROWS*TILE_H.
REQ-020 When in_panel[p] is 0, tile_row/tile_col for panel p SHALL output 0.
REQ-021 Counters SHALL saturate at PANEL_COLS-1 / PANEL_ROWS-1 and never wrap past them.
REQ-022 pix_valid low cycles SHALL hold all counter state and drive in_panel to 0.
REQ-023 frame_start SHALL be 1 for exactly one cycle when pix_valid and h_pos==0 and v_pos==0 were sampled.
REQ-024 seq_err SHALL set when two consecutive valid pixels on the same line have h_pos not incrementing by exactly 1; it stays set until rst.
REQ-025 Overlapping panels SHALL each report independently; simultaneous in_panel bits are legal.

Reset
REQ-026 While rst is high at a clk edge, all counters, in_panel, tile_row, tile_col, frame_start and seq_err SHALL be 0 on the next cycle.
REQ-027 Reset mid-frame SHALL discard line history; the first valid pixel after reset counts as a new line.

Configuration
REQ-028 With macro TILE_BORDER_EN defined, an extra output on_border (NUM_PANELS) SHALL be 1 when the pixel is in panel p and sub-x==0 or sub-y==0; without it, the port and its logic SHALL not exist.

Verification
REQ-029 Defaults, raster from (130,80): pixel (130,80) -> in_panel[0]=1, row 0, col 0 one cycle later; pixel (150,80) -> col 1.
REQ-030 Pixel (329,559) -> panel 0 row 19, col 9; pixel (330,559) -> in_panel[0]=0, indices 0.
REQ-031 Pixel (0,0) valid -> frame_start high exactly one cycle, then low.
REQ-032 h_pos sequence 200,201,203 on one line -> seq_err=1 and held until rst pulse clears it.
REQ-033 rst asserted at pixel (250,300) mid-frame, released -> all outputs 0 next cycle; next line restarts counting correctly from VSTART.
REQ-034 TILE_BORDER_EN defined: pixels (130,80) and (150,104) -> on_border[0]=1; pixel (131,81) -> 0.
